// File: rtl/alsu_seg_display.sv
// Converts the ALSU result to BCD (shift-add-3, one step per cycle) and scans
// ones/tens/error digits onto a 4-digit active-low seven-segment display.
module alsu_seg_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    input  logic        err_clr,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic        err_flag
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t        r_state;
    logic [5:0]    r_cap;
    logic [5:0]    r_sh;
    logic [7:0]    r_bcd;
    logic [2:0]    r_step;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic [CW-1:0] r_ref;
    logic [1:0]    r_sel;

    logic [3:0]    w_tens_adj;
    logic [3:0]    w_ones_adj;
    logic [6:0]    w_seg;

    function automatic logic [6:0] f_enc(input logic [3:0] d);
        case (d)
            4'd0:    f_enc = 7'b1000000;
            4'd1:    f_enc = 7'b1111001;
            4'd2:    f_enc = 7'b0100100;
            4'd3:    f_enc = 7'b0110000;
            4'd4:    f_enc = 7'b0011001;
            4'd5:    f_enc = 7'b0010010;
            4'd6:    f_enc = 7'b0000010;
            4'd7:    f_enc = 7'b1111000;
            4'd8:    f_enc = 7'b0000000;
            4'd9:    f_enc = 7'b0010000;
            default: f_enc = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    end

    // Display registers are written only from DONE, so an aborted conversion never leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cap   <= '0;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_step  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (alsu_out != r_cap) begin
                        r_cap   <= alsu_out;
                        r_sh    <= alsu_out;
                        r_bcd   <= '0;
                        r_step  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_sh} <= {w_tens_adj, w_ones_adj, r_sh, 1'b0};
                    r_step        <= r_step + 3'd1;
                    if (r_step == 3'd5)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_tens  <= r_bcd[7:4];
                    r_ones  <= r_bcd[3:0];
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_flag <= 1'b0;
        else if (|alsu_leds)
            err_flag <= 1'b1;
        else if (err_clr)
            err_flag <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
            r_sel <= '0;
        end else if (r_ref == REF_LAST) begin
            r_ref <= '0;
            r_sel <= r_sel + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_seg = f_enc(r_ones);
            2'd1:    w_seg = (r_tens == 4'd0) ? 7'b1111111 : f_enc(r_tens);
            2'd2:    w_seg = err_flag ? 7'b0000110 : 7'b1111111;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << r_sel);
            seg <= w_seg;
        end
    end
endmodule

// File: tb/tb_alsu_seg_display.sv
// Directed bench: stimulus pushes expected {tens,ones} per conversion; a monitor
// pops and compares on each busy falling edge. Scan output is checked directly.
module tb_alsu_seg_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        err_clr;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy;
    logic        err_flag;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic        prev_busy = 1'b0;

    alsu_seg_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .err_clr(err_clr), .an(an), .seg(seg), .busy(busy), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the given anode pattern, then check the cathodes.
    task automatic wait_digit(input string name, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == an_exp) found = 1;
        end
        if (!found) check({name, "_timeout"}, {28'd0, an}, {28'd0, an_exp});
        else        check(name, {25'd0, seg}, {25'd0, seg_exp});
    endtask

    task automatic convert(input logic [5:0] v, input logic [7:0] bcd, input string name);
        int cnt = 0;
        bit done = 0;
        @(posedge clk); #1;
        alsu_out = v;
        exp_q.push_back(bcd);
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) done = 1;
        end
        check({name, "_busy_cycles"}, cnt, 7);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("conv_unexpected", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("conv_bcd", {24'd0, dut.r_tens, dut.r_ones}, {24'd0, e});
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        bit saw_busy;
        int quiet;
        rst = 1'b1; alsu_out = 6'd0; alsu_leds = 16'd0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, err_flag}, 0);
        check("rst_bcd", {24'd0, dut.r_tens, dut.r_ones}, 0);
        @(posedge clk); #1; rst = 1'b0;

        saw_busy = 0;
        repeat (10) begin @(negedge clk); if (busy) saw_busy = 1; end
        check("idle_no_busy", {31'd0, saw_busy}, 0);
        wait_digit("zero_ones", 4'b1110, 7'b1000000);
        wait_digit("zero_tens_blank", 4'b1101, 7'b1111111);

        convert(6'd45, 8'h45, "v45");
        wait_digit("v45_ones", 4'b1110, 7'b0010010);
        wait_digit("v45_tens", 4'b1101, 7'b0011001);

        convert(6'd63, 8'h63, "v63");
        wait_digit("v63_ones", 4'b1110, 7'b0110000);
        wait_digit("v63_tens", 4'b1101, 7'b0000010);

        convert(6'd9, 8'h09, "v9");
        wait_digit("v9_ones", 4'b1110, 7'b0010000);
        wait_digit("v9_tens_blank", 4'b1101, 7'b1111111);
        wait_digit("digit3_blank", 4'b0111, 7'b1111111);

        // 12 then 50 two cycles later: both conversions run, 50 is final.
        @(posedge clk); #1; alsu_out = 6'd12; exp_q.push_back(8'h12);
        @(posedge clk); #1;
        @(posedge clk); #1; alsu_out = 6'd50; exp_q.push_back(8'h50);
        quiet = 0;
        for (int i = 0; i < 60 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        check("b2b_settle", quiet, 3);
        wait_digit("v50_ones", 4'b1110, 7'b1000000);
        wait_digit("v50_tens", 4'b1101, 7'b0010010);

        @(posedge clk); #1; alsu_leds = 16'hFFFF;
        @(posedge clk); #1; alsu_leds = 16'h0000;
        @(negedge clk);
        check("err_set", {31'd0, err_flag}, 1);
        wait_digit("err_digit", 4'b1011, 7'b0000110);
        @(posedge clk); #1; alsu_leds = 16'hFFFF; err_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        check("err_set_wins", {31'd0, err_flag}, 1);
        @(posedge clk); #1; alsu_leds = 16'h0000; err_clr = 1'b1;
        @(negedge clk);
        check("err_not_yet", {31'd0, err_flag}, 1);
        @(negedge clk);
        check("err_cleared", {31'd0, err_flag}, 0);
        @(posedge clk); #1; err_clr = 1'b0;
        wait_digit("err_digit_blank", 4'b1011, 7'b1111111);

        // Reset in the middle of converting 37; it restarts after release.
        @(posedge clk); #1; alsu_out = 6'd37; exp_q.push_back(8'h37);
        repeat (3) @(posedge clk);
        #1;
        check("midconv_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_an", {28'd0, an}, 32'hF);
        check("abort_seg", {25'd0, seg}, 32'h7F);
        check("abort_bcd", {24'd0, dut.r_tens, dut.r_ones}, 0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        wait_digit("v37_ones", 4'b1110, 7'b1111000);
        wait_digit("v37_tens", 4'b1101, 7'b0110000);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
